// File: rtl/times_table_arbiter_pkg.sv
// Shared definitions for the times-table arbiter slice: table geometry,
// the in-flight tag record and the round-robin priority encoding.
package tt_pkg;

  localparam int TT_ADDR_W = 6;
  localparam int TT_OP_W   = 3;
  localparam int TT_DATA_W = 6;

  // In-flight read record; a/b are only carried when the result check is built.
  typedef struct packed {
    logic               valid;
    logic               id;
    logic [TT_OP_W-1:0] a;
    logic [TT_OP_W-1:0] b;
  } tt_tag_t;

  // Which requester wins when both are valid.
  typedef enum logic {
    PRIO_0 = 1'b0,
    PRIO_1 = 1'b1
  } tt_prio_e;

  // Table address is {a,b} with a in the upper half.
  function automatic logic [TT_ADDR_W-1:0] tt_addr(input logic [TT_OP_W-1:0] a,
                                                   input logic [TT_OP_W-1:0] b);
    return {a, b};
  endfunction

endpackage

// File: rtl/times_table_arbiter_if.sv
// Request/response/memory bundle between two clients, the arbiter and the
// times-table memory. slave = arbiter view, master = client/memory view.
interface times_table_arbiter_if #(
  parameter int DATA_W = tt_pkg::TT_DATA_W
);
  logic                         req0_valid;
  logic [tt_pkg::TT_OP_W-1:0]   req0_a;
  logic [tt_pkg::TT_OP_W-1:0]   req0_b;
  logic                         req0_ready;
  logic                         rsp0_valid;
  logic [DATA_W-1:0]            rsp0_data;

  logic                         req1_valid;
  logic [tt_pkg::TT_OP_W-1:0]   req1_a;
  logic [tt_pkg::TT_OP_W-1:0]   req1_b;
  logic                         req1_ready;
  logic                         rsp1_valid;
  logic [DATA_W-1:0]            rsp1_data;

  logic                         mem_en;
  logic [tt_pkg::TT_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]            mem_dout;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mem_dout,
    output req0_ready, rsp0_valid, rsp0_data, req1_ready, rsp1_valid, rsp1_data,
           mem_en, mem_addr
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mem_dout,
    input  req0_ready, rsp0_valid, rsp0_data, req1_ready, rsp1_valid, rsp1_data,
           mem_en, mem_addr
  );
endinterface

// File: rtl/times_table_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. The priority state flips to the loser after
// every grant and holds through idle cycles.
module tt_rr_arb2
  import tt_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  tt_prio_e prio_reg;
  tt_prio_e prio_next;

  // Priority state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_reg <= PRIO_0;
    else     prio_reg <= prio_next;
  end

  // Grant decode and next priority: a lone requester always wins.
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    prio_next = prio_reg;
    if (valid0 && (!valid1 || prio_reg == PRIO_0)) begin
      grant0    = 1'b1;
      prio_next = PRIO_1;
    end else if (valid1) begin
      grant1    = 1'b1;
      prio_next = PRIO_0;
    end
  end

endmodule

// File: rtl/times_table_arbiter.sv
// Shares the single-port times-table memory between two requesters and routes
// each read result back to its issuer through a tag pipeline.
// Optional build macro TT_ARB_CHECK_EN: carries the operands with the tag and
// flags any memory result that differs from a*b (check_err / err_addr).
module times_table_arbiter
  import tt_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int DATA_W       = TT_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  times_table_arbiter_if.slave   bus
`ifdef TT_ARB_CHECK_EN
  ,
  output logic                   check_err,
  output logic [TT_ADDR_W-1:0]   err_addr
`endif
);

`ifdef TT_ARB_CHECK_EN
  localparam int TAG_W = $bits(tt_tag_t);
`else
  localparam int TAG_W = 2;
`endif

  logic               arb_g0, arb_g1;
  logic               grant0, grant1;
  logic [TT_OP_W-1:0] op_a, op_b;
  logic [TAG_W-1:0]   tag_in;
  logic [TAG_W-1:0]   tag_reg [READ_LATENCY];
  logic               fin_valid, fin_id;
  logic               rsp0_valid_reg, rsp1_valid_reg;
  logic [DATA_W-1:0]  rsp0_data_reg, rsp1_data_reg;

  tt_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .grant0 (arb_g0),
    .grant1 (arb_g1)
  );

  // Nothing is accepted and the memory stays quiet while reset is held.
  assign grant0         = arb_g0 & ~rst;
  assign grant1         = arb_g1 & ~rst;
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.mem_en     = grant0 | grant1;
  assign op_a           = grant1 ? bus.req1_a : bus.req0_a;
  assign op_b           = grant1 ? bus.req1_b : bus.req0_b;
  assign bus.mem_addr   = bus.mem_en ? tt_addr(op_a, op_b) : '0;

`ifdef TT_ARB_CHECK_EN
  tt_tag_t issue_tag;
  assign issue_tag = '{valid: bus.mem_en, id: grant1, a: op_a, b: op_b};
  assign tag_in    = issue_tag;
`else
  assign tag_in    = {bus.mem_en, grant1};
`endif

  // Tag pipeline: one stage per cycle of memory latency; the last stage lines
  // up with mem_dout.
  for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_tag
    if (gi == 0) begin : g_head
      // Load the issuing grant's tag.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) tag_reg[gi] <= '0;
        else     tag_reg[gi] <= tag_in;
      end
    end else begin : g_body
      // Advance the tag one stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) tag_reg[gi] <= '0;
        else     tag_reg[gi] <= tag_reg[gi-1];
      end
    end
  end

  assign fin_valid = tag_reg[READ_LATENCY-1][TAG_W-1];
  assign fin_id    = tag_reg[READ_LATENCY-1][TAG_W-2];

  // Response registers: pulse valid for the owner, data holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid_reg <= 1'b0;
      rsp1_valid_reg <= 1'b0;
      rsp0_data_reg  <= '0;
      rsp1_data_reg  <= '0;
    end else begin
      rsp0_valid_reg <= fin_valid & ~fin_id;
      rsp1_valid_reg <= fin_valid & fin_id;
      if (fin_valid && !fin_id) rsp0_data_reg <= bus.mem_dout;
      if (fin_valid &&  fin_id) rsp1_data_reg <= bus.mem_dout;
    end
  end

  assign bus.rsp0_valid = rsp0_valid_reg;
  assign bus.rsp1_valid = rsp1_valid_reg;
  assign bus.rsp0_data  = rsp0_data_reg;
  assign bus.rsp1_data  = rsp1_data_reg;

`ifdef TT_ARB_CHECK_EN
  tt_tag_t              done_tag;
  logic [TT_DATA_W-1:0] exp_prod;
  logic                 check_err_reg;
  logic [TT_ADDR_W-1:0] err_addr_reg;

  assign done_tag = tt_tag_t'(tag_reg[READ_LATENCY-1]);
  assign exp_prod = {3'b000, done_tag.a} * {3'b000, done_tag.b};

  // Sticky mismatch flag; the address of the first bad read is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      check_err_reg <= 1'b0;
      err_addr_reg  <= '0;
    end else if (done_tag.valid && bus.mem_dout != DATA_W'(exp_prod)) begin
      check_err_reg <= 1'b1;
      if (!check_err_reg) err_addr_reg <= tt_addr(done_tag.a, done_tag.b);
    end
  end

  assign check_err = check_err_reg;
  assign err_addr  = err_addr_reg;
`endif

endmodule

// File: tb/tb_times_table_arbiter.sv
// Directed bench for times_table_arbiter with a behavioural times-table memory
// and per-requester expected-response queues.
module tb_times_table_arbiter;
  import tt_pkg::*;

  localparam int RL = 2;

  typedef struct {
    logic [5:0] data;
    int         due;
  } exp_t;

  logic clk;
  logic rst;
  bit   corrupt;
  int   tests;
  int   fails;
  int   cyc;
  exp_t q0[$];
  exp_t q1[$];
  logic [5:0] last0, last1;
  logic [5:0] mem_pipe [RL];

  times_table_arbiter_if #(.DATA_W(6)) bus ();

`ifdef TT_ARB_CHECK_EN
  logic       check_err;
  logic [5:0] err_addr;
`endif

  times_table_arbiter #(.READ_LATENCY(RL), .DATA_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef TT_ARB_CHECK_EN
    ,
    .check_err (check_err),
    .err_addr  (err_addr)
`endif
  );

  always #5 clk = ~clk;

  // Table contents as the memory returns them (optionally corrupted at 6'o53).
  function automatic logic [5:0] table_val(input logic [5:0] addr);
    logic [5:0] p;
    p = {3'b000, addr[5:3]} * {3'b000, addr[2:0]};
    if (corrupt && addr == 6'o53) p = p ^ 6'h01;
    return p;
  endfunction

  // Memory model with RL cycles of read latency.
  always @(posedge clk) begin
    mem_pipe[0] <= table_val(bus.mem_addr);
    for (int i = 1; i < RL; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign bus.mem_dout = mem_pipe[RL-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check grant/memory/response outputs at the
  // falling edge, queue expected results for granted lookups.
  task automatic step(input bit r,
                      input bit v0, input logic [2:0] a0, input logic [2:0] b0,
                      input bit v1, input logic [2:0] a1, input logic [2:0] b1,
                      input bit eg0, input bit eg1);
    exp_t       e;
    logic [5:0] ea;
    rst            = r;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
    if (r) begin
      q0.delete(); q1.delete();
      last0 = '0; last1 = '0;
    end
    @(negedge clk);
    ea = eg0 ? {a0, b0} : (eg1 ? {a1, b1} : 6'd0);
    chk("req0_ready", 32'(bus.req0_ready), 32'(eg0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(eg1));
    chk("mem_en",     32'(bus.mem_en),     32'(eg0 | eg1));
    chk("mem_addr",   32'(bus.mem_addr),   32'(ea));
    if (q0.size() > 0 && q0[0].due == cyc) begin
      e = q0.pop_front();
      chk("rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
      chk("rsp0_data",  32'(bus.rsp0_data),  32'(e.data));
      last0 = e.data;
    end else begin
      chk("rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
      chk("rsp0_hold",  32'(bus.rsp0_data),  32'(last0));
    end
    if (q1.size() > 0 && q1[0].due == cyc) begin
      e = q1.pop_front();
      chk("rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
      chk("rsp1_data",  32'(bus.rsp1_data),  32'(e.data));
      last1 = e.data;
    end else begin
      chk("rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
      chk("rsp1_hold",  32'(bus.rsp1_data),  32'(last1));
    end
    if (eg0) q0.push_back('{data: table_val({a0, b0}), due: cyc + RL + 1});
    if (eg1) q1.push_back('{data: table_val({a1, b1}), due: cyc + RL + 1});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 3'd0, 3'd0, 0, 3'd0, 3'd0, 0, 0);
  endtask

  initial begin
    clk = 0; rst = 1; corrupt = 0; tests = 0; fails = 0; cyc = 0;
    last0 = '0; last1 = '0;
    bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0;

    // Reset: requests are ignored, outputs are zero.
    for (int i = 0; i < 3; i++) step(1, 1, 3'd1, 3'd1, 1, 3'd2, 3'd2, 0, 0);
    idle(1);

    // Contention from prio=0: grants alternate, responses interleave 49/12.
    step(0, 1, 3'd7, 3'd7, 1, 3'd2, 3'd6, 1, 0);
    step(0, 1, 3'd7, 3'd7, 1, 3'd2, 3'd6, 0, 1);
    step(0, 1, 3'd7, 3'd7, 1, 3'd2, 3'd6, 1, 0);
    step(0, 1, 3'd7, 3'd7, 1, 3'd2, 3'd6, 0, 1);
    idle(RL + 2);

    // Single request 3x5: address 6'o35, result 15.
    step(0, 1, 3'd3, 3'd5, 0, 3'd0, 3'd0, 1, 0);
    idle(RL + 2);

    // Priority hold across idle cycles.
    step(0, 0, 3'd0, 3'd0, 1, 3'd1, 3'd1, 0, 1);
    idle(3);
    step(0, 1, 3'd2, 3'd2, 1, 3'd3, 3'd3, 1, 0);
    step(0, 1, 3'd2, 3'd2, 1, 3'd3, 3'd3, 0, 1);
    idle(RL + 2);

    // Stall: req1 4x4 loses once, then is granted with operands held.
    step(0, 1, 3'd2, 3'd3, 1, 3'd4, 3'd4, 1, 0);
    step(0, 0, 3'd0, 3'd0, 1, 3'd4, 3'd4, 0, 1);
    idle(RL + 2);

    // Reset mid-flight: the 6x6 read is dropped, prio returns to 0.
    step(0, 1, 3'd6, 3'd6, 0, 3'd0, 3'd0, 1, 0);
    step(1, 0, 3'd0, 3'd0, 0, 3'd0, 3'd0, 0, 0);
    step(1, 0, 3'd0, 3'd0, 0, 3'd0, 3'd0, 0, 0);
    idle(RL + 2);
    step(0, 1, 3'd1, 3'd2, 1, 3'd1, 3'd3, 1, 0);
    idle(RL + 2);

    // Exhaustive back-to-back sweep from requester 0.
    for (int i = 0; i < 64; i++) begin
      logic [5:0] ab;
      ab = 6'(i);
      step(0, 1, ab[5:3], ab[2:0], 0, 3'd0, 3'd0, 1, 0);
    end
    idle(RL + 2);

`ifdef TT_ARB_CHECK_EN
    chk("check_err_clean", 32'(check_err), 32'd0);
    chk("err_addr_clean",  32'(err_addr),  32'd0);
    corrupt = 1;
    step(0, 1, 3'd5, 3'd3, 0, 3'd0, 3'd0, 1, 0);
    step(0, 1, 3'd7, 3'd2, 0, 3'd0, 3'd0, 1, 0);
    idle(RL + 2);
    chk("check_err_set",   32'(check_err), 32'd1);
    chk("err_addr_first",  32'(err_addr),  32'(6'o53));
    corrupt = 0;
`endif

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
